// File: rtl/conv_loop_sequencer.sv
// Restartable FSM that walks the six-deep conv loop nest (to,row,col,ti,i,j)
// and issues one registered address beat per accepted valid/ready handshake.
module conv_loop_sequencer #(
    parameter int TM = 7,
    parameter int TN = 3,
    parameter int TR = 10,
    parameter int TC = 10,
    parameter int K  = 6,
    parameter int S  = 1,
    parameter int AW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          pe_ready_i,
    output logic          beat_vld_o,
    output logic [AW-1:0] in_addr_o,
    output logic [AW-1:0] wt_addr_o,
    output logic [AW-1:0] out_addr_o,
    output logic          acc_clr_o,
    output logic          acc_last_o,
    output logic          busy_o,
    output logic          done_o
);
    localparam int IN_W = S * (TC - 1) + K;
    localparam int IN_H = S * (TR - 1) + K;
    localparam int TMW  = $clog2(TM > 1 ? TM : 2);
    localparam int TNW  = $clog2(TN > 1 ? TN : 2);
    localparam int TRW  = $clog2(TR > 1 ? TR : 2);
    localparam int TCW  = $clog2(TC > 1 ? TC : 2);
    localparam int KW   = $clog2(K > 1 ? K : 2);
    localparam logic LAST0 = (TN == 1) && (K == 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [TMW-1:0]   to_q, to_d;
    logic [TRW-1:0]   row_q, row_d;
    logic [TCW-1:0]   col_q, col_d;
    logic [TNW-1:0]   ti_q, ti_d;
    logic [KW-1:0]    i_q, i_d, j_q, j_d;
    logic             vld_q, clr_q, last_q, busy_q, done_q;
    logic [AW-1:0]    in_q, wt_q, out_q;
    logic [AW-1:0]    in_nx, wt_nx, out_nx;
    logic             clr_nx, last_nx;
    logic             w_j, w_i, w_ti, w_col, w_row, w_to, final_beat;

    // Odometer carry chain: j is the fastest digit, to the slowest.
    always_comb begin
        w_j   = (j_q   == KW'(K - 1));
        w_i   = (i_q   == KW'(K - 1));
        w_ti  = (ti_q  == TNW'(TN - 1));
        w_col = (col_q == TCW'(TC - 1));
        w_row = (row_q == TRW'(TR - 1));
        w_to  = (to_q  == TMW'(TM - 1));
        final_beat = w_j && w_i && w_ti && w_col && w_row && w_to;

        j_d   = w_j ? '0 : j_q + 1'b1;
        i_d   = i_q;
        ti_d  = ti_q;
        col_d = col_q;
        row_d = row_q;
        to_d  = to_q;
        if (w_j)                             i_d   = w_i   ? '0 : i_q + 1'b1;
        if (w_j && w_i)                      ti_d  = w_ti  ? '0 : ti_q + 1'b1;
        if (w_j && w_i && w_ti)              col_d = w_col ? '0 : col_q + 1'b1;
        if (w_j && w_i && w_ti && w_col)     row_d = w_row ? '0 : row_q + 1'b1;
        if (w_j && w_i && w_ti && w_col && w_row) to_d = w_to ? '0 : to_q + 1'b1;

        in_nx  = AW'(ti_d) * AW'(IN_H * IN_W)
               + (AW'(S) * AW'(row_d) + AW'(i_d)) * AW'(IN_W)
               + AW'(S) * AW'(col_d) + AW'(j_d);
        wt_nx  = ((AW'(to_d) * AW'(TN) + AW'(ti_d)) * AW'(K) + AW'(i_d)) * AW'(K) + AW'(j_d);
        out_nx = (AW'(to_d) * AW'(TR) + AW'(row_d)) * AW'(TC) + AW'(col_d);
        clr_nx  = (ti_d == '0) && (i_d == '0) && (j_d == '0);
        last_nx = (ti_d == TNW'(TN - 1)) && (i_d == KW'(K - 1)) && (j_d == KW'(K - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            to_q <= '0; row_q <= '0; col_q <= '0; ti_q <= '0; i_q <= '0; j_q <= '0;
            vld_q <= 1'b0; in_q <= '0; wt_q <= '0; out_q <= '0;
            clr_q <= 1'b0; last_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        state_q <= RUN;
                        to_q <= '0; row_q <= '0; col_q <= '0; ti_q <= '0; i_q <= '0; j_q <= '0;
                        vld_q  <= 1'b1;
                        in_q   <= '0; wt_q <= '0; out_q <= '0;
                        clr_q  <= 1'b1;
                        last_q <= LAST0;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_i || (vld_q && pe_ready_i && final_beat)) begin
                        // Abort and end-of-pass both park the counters at zero.
                        state_q <= abort_i ? IDLE : DONE;
                        done_q  <= !abort_i;
                        to_q <= '0; row_q <= '0; col_q <= '0; ti_q <= '0; i_q <= '0; j_q <= '0;
                        vld_q <= 1'b0; in_q <= '0; wt_q <= '0; out_q <= '0;
                        clr_q <= 1'b0; last_q <= 1'b0; busy_q <= 1'b0;
                    end else if (vld_q && pe_ready_i) begin
                        to_q <= to_d; row_q <= row_d; col_q <= col_d;
                        ti_q <= ti_d; i_q <= i_d; j_q <= j_d;
                        in_q   <= in_nx;
                        wt_q   <= wt_nx;
                        out_q  <= out_nx;
                        clr_q  <= clr_nx;
                        last_q <= last_nx;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign beat_vld_o = vld_q;
    assign in_addr_o  = in_q;
    assign wt_addr_o  = wt_q;
    assign out_addr_o = out_q;
    assign acc_clr_o  = clr_q;
    assign acc_last_o = last_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Three small configurations driven in lockstep, each checked against a
// nested-loop beat list and a three-state pass model.
module tb_conv_loop_sequencer;
    typedef struct packed {
        logic [15:0] in;
        logic [15:0] wt;
        logic [15:0] out;
        logic        clr;
        logic        last;
    } beat_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, rdy = 1'b0;
    logic [2:0] vld, clr, lst, busy, done;
    logic [15:0] ina [3];
    logic [15:0] wta [3];
    logic [15:0] outa [3];

    int tests = 0, fails = 0;
    beat_t expq [3][$];
    int mst [3];
    int midx [3];
    int dcnt [3];
    logic [15:0] first0 [3];
    logic [15:0] last0 [3];
    logic [15:0] c1in [4];

    always #5 clk = ~clk;

    conv_loop_sequencer #(.TM(2), .TN(1), .TR(2), .TC(2), .K(2), .S(1), .AW(16)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pe_ready_i(rdy),
        .beat_vld_o(vld[0]), .in_addr_o(ina[0]), .wt_addr_o(wta[0]), .out_addr_o(outa[0]),
        .acc_clr_o(clr[0]), .acc_last_o(lst[0]), .busy_o(busy[0]), .done_o(done[0]));
    conv_loop_sequencer #(.TM(1), .TN(1), .TR(2), .TC(2), .K(2), .S(2), .AW(16)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pe_ready_i(rdy),
        .beat_vld_o(vld[1]), .in_addr_o(ina[1]), .wt_addr_o(wta[1]), .out_addr_o(outa[1]),
        .acc_clr_o(clr[1]), .acc_last_o(lst[1]), .busy_o(busy[1]), .done_o(done[1]));
    conv_loop_sequencer #(.TM(1), .TN(2), .TR(2), .TC(2), .K(2), .S(1), .AW(16)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pe_ready_i(rdy),
        .beat_vld_o(vld[2]), .in_addr_o(ina[2]), .wt_addr_o(wta[2]), .out_addr_o(outa[2]),
        .acc_clr_o(clr[2]), .acc_last_o(lst[2]), .busy_o(busy[2]), .done_o(done[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void gen(int x, int tm, int tn, int tr, int tc, int k, int s);
        int iw, ih;
        beat_t b;
        iw = s * (tc - 1) + k;
        ih = s * (tr - 1) + k;
        for (int to = 0; to < tm; to++)
          for (int r = 0; r < tr; r++)
            for (int c = 0; c < tc; c++)
              for (int ti = 0; ti < tn; ti++)
                for (int i = 0; i < k; i++)
                  for (int j = 0; j < k; j++) begin
                      b.in   = 16'(ti * ih * iw + (s * r + i) * iw + s * c + j);
                      b.wt   = 16'(((to * tn + ti) * k + i) * k + j);
                      b.out  = 16'((to * tr + r) * tc + c);
                      b.clr  = (ti == 0) && (i == 0) && (j == 0);
                      b.last = (ti == tn - 1) && (i == k - 1) && (j == k - 1);
                      expq[x].push_back(b);
                  end
    endfunction

    // Called at a falling edge with inputs already driven: check, then model the next rising edge.
    task automatic tick();
        beat_t got;
        for (int x = 0; x < 3; x++) begin
            chk($sformatf("vld%0d", x), 64'(vld[x]), 64'(mst[x] == 1));
            chk($sformatf("busy%0d", x), 64'(busy[x]), 64'(mst[x] == 1));
            chk($sformatf("done%0d", x), 64'(done[x]), 64'(mst[x] == 2));
            if (done[x]) dcnt[x]++;
            if (mst[x] == 1 && midx[x] < expq[x].size()) begin
                got = '{ina[x], wta[x], outa[x], clr[x], lst[x]};
                chk($sformatf("beat%0d_%0d", x, midx[x]), 64'(got), 64'(expq[x][midx[x]]));
                if (x == 0 && midx[x] == 0)  first0[0] = ina[0] | wta[0] | outa[0];
                if (x == 0 && midx[x] == 31) begin last0[0] = ina[0]; last0[1] = wta[0]; last0[2] = outa[0]; end
                if (x == 1 && midx[x] >= 4 && midx[x] <= 7) c1in[midx[x] - 4] = ina[1];
            end
        end
        for (int x = 0; x < 3; x++) begin
            case (mst[x])
                0: if (start && !abort) begin mst[x] = 1; midx[x] = 0; end
                1: if (abort) mst[x] = 0;
                   else if (rdy) begin
                       midx[x]++;
                       if (midx[x] == expq[x].size()) mst[x] = 2;
                   end
                default: mst[x] = 0;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_idle(input bit rnd, input int start_at);
        int c;
        for (c = 0; c < 400; c++) begin
            rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (c == start_at);
            tick();
            if (mst[0] == 0 && mst[1] == 0 && mst[2] == 0) break;
        end
        start = 1'b0;
        chk("pass_timeout", 64'(c < 400), 64'(1));
    endtask

    initial begin
        gen(0, 2, 1, 2, 2, 2, 1);
        gen(1, 1, 1, 2, 2, 2, 2);
        gen(2, 1, 2, 2, 2, 2, 1);
        for (int x = 0; x < 3; x++) begin mst[x] = 0; midx[x] = 0; dcnt[x] = 0; end
        @(negedge clk);
        @(negedge clk);
        for (int x = 0; x < 3; x++)
            chk($sformatf("rst_out%0d", x),
                64'({vld[x], ina[x], wta[x], outa[x], clr[x], lst[x], busy[x], done[x]}), 64'(0));
        rst = 1'b0;
        tick();

        // Full-rate pass.
        first0[0] = 16'hFFFF;
        start = 1'b1; rdy = 1'b1; tick(); start = 1'b0;
        run_idle(1'b0, -1);
        chk("t1_first", 64'(first0[0]), 64'(0));
        chk("t1_last_in", 64'(last0[0]), 64'(8));
        chk("t1_last_wt", 64'(last0[1]), 64'(7));
        chk("t1_last_out", 64'(last0[2]), 64'(7));
        chk("t3_col1", 64'({c1in[0], c1in[1], c1in[2], c1in[3]}), 64'({16'd2, 16'd3, 16'd6, 16'd7}));
        for (int x = 0; x < 3; x++) chk($sformatf("done_cnt%0d", x), 64'(dcnt[x]), 64'(1));

        // Backpressure pass with a stray start mid-run.
        start = 1'b1; tick(); start = 1'b0;
        run_idle(1'b1, 5);

        // start and abort together in idle stays idle.
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        tick();

        // Abort at beat 10, then restart from zero.
        for (int x = 0; x < 3; x++) dcnt[x] = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 100 && midx[0] < 10; c++) begin rdy = 1'($urandom_range(0, 1)); tick(); end
        abort = 1'b1; rdy = 1'b1; tick(); abort = 1'b0;
        chk("abort_vld", 64'(vld[0]), 64'(0));
        tick();
        for (int x = 0; x < 3; x++) chk($sformatf("abort_done%0d", x), 64'(dcnt[x]), 64'(0));
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_zero", 64'({ina[0], wta[0], outa[0]}), 64'(0));
        run_idle(1'b1, -1);

        // Async reset between edges.
        start = 1'b1; rdy = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #1 rst = 1'b1;
        #1;
        for (int x = 0; x < 3; x++)
            chk($sformatf("async_rst%0d", x),
                64'({vld[x], ina[x], wta[x], outa[x], clr[x], lst[x], busy[x], done[x]}), 64'(0));
        for (int x = 0; x < 3; x++) mst[x] = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
